// File: rtl/data_memory_ctrl_pkg.sv
// rtl/data_memory_ctrl_pkg.sv - shared constants and state encoding for the line-granular data memory
package data_memory_ctrl_pkg;

    localparam int LINE_W          = 256;
    localparam int OFFSET_W        = 5;
    localparam int DEFAULT_LATENCY = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - cache-to-memory line request bus
interface data_memory_ctrl_if;
    import data_memory_ctrl_pkg::*;

    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    modport master (
        output addr_i, data_i, enable_i, write_i,
        input  ack_o, data_o
    );

    modport slave (
        input  addr_i, data_i, enable_i, write_i,
        output ack_o, data_o
    );

endinterface

// File: rtl/data_memory_ctrl_array.sv
// rtl/data_memory_ctrl_array.sv - DEPTH x 256-bit single-port synchronous RAM with registered read
module data_memory_array
    import data_memory_ctrl_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] index,
    input  logic [LINE_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - fixed-latency backing memory serving one cache line request at a time
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_memory_ctrl_if.slave  bus
);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;

    logic [ADDR_W-1:0] idx_q;
    logic              wr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              capture;

    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] arr_idx;
    logic [LINE_W-1:0] arr_wdata;
    logic              arr_we, arr_re;
    logic              arr_we_g, arr_re_g;
    logic [LINE_W-1:0] arr_rdata;
    logic              unused_addr;

    // Offset bits and index bits above ADDR_W are don't-care: lines wrap modulo DEPTH.
    assign req_idx     = bus.addr_i[ADDR_W+OFFSET_W-1:OFFSET_W];
    assign unused_addr = ^{bus.addr_i[31:ADDR_W+OFFSET_W], bus.addr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (capture) begin
            idx_q   <= req_idx;
            wr_q    <= bus.write_i;
            wdata_q <= bus.data_i;
        end
    end

    // The single array access happens on the edge that enters ACK; with LATENCY=1
    // that is the accept edge itself, so the live request is routed straight through.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        arr_idx   = idx_q;
        arr_wdata = wdata_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable_i) begin
                    capture = 1'b1;
                    cnt_d   = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d   = ST_ACK;
                        arr_idx   = req_idx;
                        arr_wdata = bus.data_i;
                        arr_we    = bus.write_i;
                        arr_re    = !bus.write_i;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_ACK;
                    arr_we  = wr_q;
                    arr_re  = !wr_q;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // No array access may slip through while reset is held.
    assign arr_we_g   = arr_we && rst_i;
    assign arr_re_g   = arr_re && rst_i;
    assign rd_valid_d = rd_valid_q || arr_re_g;

    data_memory_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk_i),
        .index (arr_idx),
        .wdata (arr_wdata),
        .we    (arr_we_g),
        .re    (arr_re_g),
        .rdata (arr_rdata)
    );

    // The RAM read register has no reset, so data_o reads zero until the first read lands.
    assign bus.ack_o  = (state_q == ST_ACK);
    assign bus.data_o = rd_valid_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized self-checking bench for data_memory_ctrl (LATENCY 10 and 1)
module tb_data_memory_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         en [2];
    logic         wr [2];
    logic [31:0]  ad [2];
    logic [255:0] wd [2];

    data_memory_ctrl_if bus0 ();
    data_memory_ctrl_if bus1 ();

    assign bus0.enable_i = en[0];
    assign bus0.write_i  = wr[0];
    assign bus0.addr_i   = ad[0];
    assign bus0.data_i   = wd[0];
    assign bus1.enable_i = en[1];
    assign bus1.write_i  = wr[1];
    assign bus1.addr_i   = ad[1];
    assign bus1.data_i   = wd[1];

    data_memory_ctrl #(.LATENCY(10), .DEPTH(512), .ADDR_W(9)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus0)
    );

    data_memory_ctrl #(.LATENCY(1), .DEPTH(512), .ADDR_W(9)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus1)
    );

    // Reference memory: one entry per line index, keyed by plain address arithmetic.
    logic [255:0] model [2][int];
    int           lat_of [2] = '{10, 1};

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % 512);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic ack_of(input int sel);
        return (sel == 1) ? bus1.ack_o : bus0.ack_o;
    endfunction

    function automatic logic [255:0] dout_of(input int sel);
        return (sel == 1) ? bus1.data_o : bus0.data_o;
    endfunction

    // Drives one request from a negedge; returns accept-to-ack-sample latency in cycles,
    // data seen in the ack cycle, the cycle number of the ack, and whether ack fell after one cycle.
    task automatic do_req(input int sel, input bit w, input logic [31:0] a, input logic [255:0] d,
                          input bit keep, input int chg_at, input logic [31:0] ca, input logic [255:0] cd,
                          output logic [255:0] rd, output int lat, output int ack_cyc, output bit narrow);
        en[sel] = 1'b1;
        wr[sel] = w;
        ad[sel] = a;
        wd[sel] = d;
        @(posedge clk);
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == chg_at) begin
                ad[sel] = ca;
                wd[sel] = cd;
            end
            if (ack_of(sel)) break;
        end
        rd      = dout_of(sel);
        ack_cyc = cyc;
        if (!keep) en[sel] = 1'b0;
        @(negedge clk);
        narrow = !ack_of(sel);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            en[s] = 1'b0; wr[s] = 1'b0; ad[s] = '0; wd[s] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus0.ack_o !== 1'b0 || bus0.data_o !== '0 || bus1.ack_o !== 1'b0 || bus1.data_o !== '0) begin
                $display("FAIL reset_idle cyc%0d: ack=%b/%b data_nonzero=%b/%b, want ack 0 data 0",
                         i, bus0.ack_o, bus1.ack_o, |bus0.data_o, |bus1.data_o);
                n_err++;
            end
        end
    endtask

    task automatic test_write_read();
        logic [255:0] rd, pat;
        int lat, ac;
        bit nw;
        pat = {8{32'hDEAD_BEEF}};
        do_req(0, 1'b1, 32'h0000_0040, pat, 1'b0, 0, '0, '0, rd, lat, ac, nw);
        model[0][line_of(32'h40)] = pat;
        n_cmp++;
        if (lat !== 10 || !nw) begin
            $display("FAIL wr_ack_timing: lat=%0d one_cycle=%0d, want 10/1", lat, nw); n_err++;
        end
        do_req(0, 1'b0, 32'h0000_0040, rand_line(), 1'b0, 0, '0, '0, rd, lat, ac, nw);
        n_cmp++;
        if (lat !== 10 || !nw) begin
            $display("FAIL rd_ack_timing: lat=%0d one_cycle=%0d, want 10/1", lat, nw); n_err++;
        end
        n_cmp++;
        if (rd !== pat) begin
            $display("FAIL rd_after_wr: got %h want %h", rd, pat); n_err++;
        end
    endtask

    task automatic test_offset_wrap();
        logic [255:0] rd, pa, pb;
        int lat, ac;
        bit nw;
        pa = rand_line();
        pb = rand_line();
        do_req(0, 1'b1, 32'h0000_0060, pa, 1'b0, 0, '0, '0, rd, lat, ac, nw);
        model[0][line_of(32'h60)] = pa;
        do_req(0, 1'b0, 32'h0000_007C, '0, 1'b0, 0, '0, '0, rd, lat, ac, nw);
        n_cmp++;
        if (rd !== model[0][line_of(32'h7C)]) begin
            $display("FAIL offset_ignored: got %h want %h", rd, model[0][line_of(32'h7C)]); n_err++;
        end
        do_req(0, 1'b1, 32'h0000_4060, pb, 1'b0, 0, '0, '0, rd, lat, ac, nw);
        model[0][line_of(32'h4060)] = pb;
        do_req(0, 1'b0, 32'h0000_0060, '0, 1'b0, 0, '0, '0, rd, lat, ac, nw);
        n_cmp++;
        if (rd !== model[0][line_of(32'h60)] || rd !== pb) begin
            $display("FAIL index_wrap: got %h want %h", rd, pb); n_err++;
        end
    endtask

    task automatic test_back_to_back(input int sel);
        logic [255:0] rd, pat;
        int lat1, lat2, c1, c2;
        bit n1, n2;
        logic [31:0] a;
        a = 32'h0000_03C0 + 32'(sel) * 32'h20;
        pat = rand_line();
        do_req(sel, 1'b1, a, pat, 1'b1, 0, '0, '0, rd, lat1, c1, n1);
        model[sel][line_of(a)] = pat;
        do_req(sel, 1'b0, a, '0, 1'b0, 0, '0, '0, rd, lat2, c2, n2);
        n_cmp++;
        if (c2 - c1 !== lat_of[sel] + 1 || lat2 !== lat_of[sel]) begin
            $display("FAIL b2b_spacing dut%0d: ack gap=%0d lat2=%0d, want %0d/%0d",
                     sel, c2 - c1, lat2, lat_of[sel] + 1, lat_of[sel]); n_err++;
        end
        n_cmp++;
        if (rd !== model[sel][line_of(a)]) begin
            $display("FAIL b2b_refill dut%0d: got %h want %h", sel, rd, pat); n_err++;
        end
    endtask

    task automatic test_input_change();
        logic [255:0] rd, orig;
        int lat, ac;
        bit nw;
        int lines [4] = '{4, 5, 6, 77};
        foreach (lines[i]) begin
            model[0][lines[i]] = rand_line();
            do_req(0, 1'b1, 32'(lines[i]) * 32, model[0][lines[i]], 1'b0, 0, '0, '0, rd, lat, ac, nw);
        end
        orig = rand_line();
        do_req(0, 1'b1, 32'd5 * 32, orig, 1'b0, 3, 32'd77 * 32, rand_line(), rd, lat, ac, nw);
        model[0][5] = orig;
        foreach (lines[i]) begin
            do_req(0, 1'b0, 32'(lines[i]) * 32, '0, 1'b0, 0, '0, '0, rd, lat, ac, nw);
            n_cmp++;
            if (rd !== model[0][lines[i]]) begin
                $display("FAIL wait_input_change line%0d: got %h want %h", lines[i], rd, model[0][lines[i]]); n_err++;
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [255:0] rd;
        int lat, ac;
        bit nw, seen;
        model[0][9] = rand_line();
        do_req(0, 1'b1, 32'd9 * 32, model[0][9], 1'b0, 0, '0, '0, rd, lat, ac, nw);
        en[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'd9 * 32; wd[0] = rand_line();
        @(posedge clk);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen |= bus0.ack_o;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen |= bus0.ack_o;
            n_cmp++;
            if (bus0.data_o !== '0) begin
                $display("FAIL reset_data_o: got %h want 0", bus0.data_o); n_err++;
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen |= bus0.ack_o;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            $display("FAIL reset_drop_ack: ack seen=%b want 0", seen); n_err++;
        end
        do_req(0, 1'b0, 32'd9 * 32, '0, 1'b0, 0, '0, '0, rd, lat, ac, nw);
        n_cmp++;
        if (lat !== 10 || !nw) begin
            $display("FAIL post_reset_lat: lat=%0d one_cycle=%0d want 10/1", lat, nw); n_err++;
        end
        n_cmp++;
        if (rd !== model[0][9]) begin
            $display("FAIL reset_no_commit: got %h want %h", rd, model[0][9]); n_err++;
        end
    endtask

    task automatic test_latency1();
        logic [255:0] rd, pat;
        int lat, ac;
        bit nw;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = $urandom;
            pat = rand_line();
            do_req(1, 1'b1, a, pat, 1'b0, 0, '0, '0, rd, lat, ac, nw);
            model[1][line_of(a)] = pat;
            n_cmp++;
            if (lat !== 1 || !nw) begin
                $display("FAIL lat1_wr: lat=%0d one_cycle=%0d want 1/1", lat, nw); n_err++;
            end
            do_req(1, 1'b0, a ^ 32'h1F, '0, 1'b0, 0, '0, '0, rd, lat, ac, nw);
            n_cmp++;
            if (lat !== 1 || rd !== model[1][line_of(a)]) begin
                $display("FAIL lat1_rd: lat=%0d got %h want 1/%h", lat, rd, model[1][line_of(a)]); n_err++;
            end
        end
    endtask

    task automatic test_random();
        logic [255:0] rd, last_rd, pat;
        int lat, ac;
        bit nw, have_rd;
        int lines [8];
        have_rd = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 8; i++) begin
            lines[i] = 100 + i * 37;
            model[0][lines[i]] = rand_line();
            do_req(0, 1'b1, 32'(lines[i]) * 32, model[0][lines[i]], 1'b0, 0, '0, '0, rd, lat, ac, nw);
        end
        for (int n = 0; n < 40; n++) begin
            int li;
            bit w;
            logic [31:0] a;
            li = lines[$urandom_range(0, 7)];
            a  = ($urandom & 32'hFFFF_C000) | (32'(li) << 5) | ($urandom & 32'h1F);
            w  = $urandom_range(0, 1) == 1;
            pat = rand_line();
            do_req(0, w, a, pat, 1'b0, 0, '0, '0, rd, lat, ac, nw);
            n_cmp++;
            if (lat !== 10 || !nw) begin
                $display("FAIL rand_timing op%0d: lat=%0d one_cycle=%0d want 10/1", n, lat, nw); n_err++;
            end
            if (w) begin
                model[0][line_of(a)] = pat;
            end else begin
                n_cmp++;
                if (rd !== model[0][line_of(a)]) begin
                    $display("FAIL rand_read op%0d line%0d: got %h want %h", n, line_of(a), rd, model[0][line_of(a)]); n_err++;
                end
                last_rd = model[0][line_of(a)];
                have_rd = 1'b1;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (have_rd) begin
                n_cmp++;
                if (bus0.data_o !== last_rd) begin
                    $display("FAIL data_o_hold op%0d: got %h want %h", n, bus0.data_o, last_rd); n_err++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_offset_wrap();
        test_back_to_back(0);
        test_back_to_back(1);
        test_input_change();
        test_reset_mid_wait();
        test_latency1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
